// File: rtl/ext_pipe.sv
// ext_pipe: IN_W->OUT_W immediate/data extender (zero, sign, upper, byte-sign)
// feeding a 2-entry skid buffer. Optional pop counter under EXT_PIPE_COUNT_EN.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  data_in,
    input  logic [1:0]       mode,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic [TAG_W-1:0] tag_out
`ifdef EXT_PIPE_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t     head, tail, in_ent;
    logic [1:0] count;
    logic       push, pop;

    // Casts rather than replication so IN_W == OUT_W needs no zero-width repeat.
    always_comb begin
        in_ent.data = '0;
        in_ent.tag  = tag_in;
        case (mode)
            2'b00: in_ent.data = OUT_W'(data_in);
            2'b01: in_ent.data = $unsigned(OUT_W'($signed(data_in)));
            2'b10: in_ent.data = OUT_W'(data_in) << (OUT_W - IN_W);
            2'b11: in_ent.data = $unsigned(OUT_W'($signed(data_in[7:0])));
            default: in_ent.data = '0;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign data_out  = out_valid ? head.data : '0;
    assign tag_out   = out_valid ? head.tag  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_ent;
                    else               tail <= in_ent;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    tail  <= '0;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop only happens at count 1: new entry replaces head.
                2'b11: head <= in_ent;
                default: ;
            endcase
        end
    end

`ifdef EXT_PIPE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   xfer_count <= 16'd0;
        else if (pop) xfer_count <= xfer_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Directed, table-driven bench for ext_pipe: extension modes, backpressure,
// streaming, async reset, IN_W == OUT_W instance and optional pop counter.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic [4:0]  tag_in, tag_out;
    logic [31:0] data_out;

    logic        v16, r16, ov16, or16;
    logic [15:0] d16, do16;
    logic [1:0]  m16;
    logic [4:0]  t16, to16;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef EXT_PIPE_COUNT_EN
    logic [15:0] xfer_count, xfer16;
`endif

    always #5 clk = ~clk;

    ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .mode(mode), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .tag_out(tag_out)
`ifdef EXT_PIPE_COUNT_EN
        , .xfer_count(xfer_count)
`endif
    );

    ext_pipe #(.IN_W(16), .OUT_W(16), .TAG_W(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(r16),
        .data_in(d16), .mode(m16), .tag_in(t16),
        .out_valid(ov16), .out_ready(or16),
        .data_out(do16), .tag_out(to16)
`ifdef EXT_PIPE_COUNT_EN
        , .xfer_count(xfer16)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Producer must hold in_valid while stalled.
    logic stall_q = 1'b0;
    always @(posedge clk) begin
        if (rst_n && stall_q) begin
            n_checks++;
            if (!in_valid) begin
                n_fail++;
                $display("FAIL protocol: in_valid dropped while stalled at %0t", $time);
            end
        end
        stall_q = rst_n && in_valid && !in_ready;
    end

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] din;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [15:0] cnt_base;

    initial begin
        vecs[0] = '{2'b01, 16'h8001, 5'd3, 32'hFFFF8001};
        vecs[1] = '{2'b00, 16'h80F0, 5'd1, 32'h000080F0};
        vecs[2] = '{2'b10, 16'h80F0, 5'd2, 32'h80F00000};
        vecs[3] = '{2'b11, 16'h80F0, 5'd4, 32'hFFFFFFF0};
        vecs[4] = '{2'b01, 16'h7FFF, 5'd7, 32'h00007FFF};
        vecs[5] = '{2'b11, 16'hFF7F, 5'd9, 32'h0000007F};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_in = '0; mode = '0; tag_in = '0;
        v16 = 1'b0; or16 = 1'b1; d16 = '0; m16 = '0; t16 = '0;
        cnt_base = '0;
        step(); step();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst data_out", data_out, 32'd0);
        chk("rst tag_out", 32'(tag_out), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
`ifdef EXT_PIPE_COUNT_EN
        chk("rst xfer_count", 32'(xfer_count), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Single transfers through each extension mode.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; mode = vecs[i].mode; data_in = vecs[i].din; tag_in = vecs[i].tag;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d data_out", i), data_out, vecs[i].exp);
            chk($sformatf("vec%0d tag_out", i), 32'(tag_out), 32'(vecs[i].tag));
            step();
            chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d data zero", i), data_out, 32'd0);
        end

        // Backpressure: two accepted, third held until a slot frees.
        out_ready = 1'b0; mode = 2'b00;
        in_valid = 1'b1; data_in = 16'h0011; tag_in = 5'd1;
        step();
        chk("bp A head", data_out, 32'h11);
        chk("bp ready after 1", 32'(in_ready), 32'd1);
        data_in = 16'h0022; tag_in = 5'd2;
        step();
        chk("bp ready after 2", 32'(in_ready), 32'd0);
        data_in = 16'h0033; tag_in = 5'd3;
        step();
        chk("bp still full", 32'(in_ready), 32'd0);
        chk("bp head held", data_out, 32'h11);
        out_ready = 1'b1;
        step();
        chk("bp pop A -> B", data_out, 32'h22);
        chk("bp B tag", 32'(tag_out), 32'd2);
        chk("bp ready after pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp pop B -> C", data_out, 32'h33);
        chk("bp C tag", 32'(tag_out), 32'd3);
        step();
        chk("bp empty", 32'(out_valid), 32'd0);

        // Streaming at one transfer per cycle.
`ifdef EXT_PIPE_COUNT_EN
        cnt_base = xfer_count;
`endif
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1; data_in = 16'(c + 16'h0100); tag_in = 5'(c);
            step();
            chk($sformatf("stream %0d", c), data_out, 32'(c + 16'h0100));
            chk($sformatf("stream %0d ready", c), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", 32'(out_valid), 32'd0);
`ifdef EXT_PIPE_COUNT_EN
        chk("stream xfer_count", 32'(xfer_count - cnt_base), 32'd100);
`endif

        // Async reset with two entries buffered.
        out_ready = 1'b0; mode = 2'b01;
        in_valid = 1'b1; data_in = 16'hAAAA; tag_in = 5'd5;
        step();
        data_in = 16'hBBBB; tag_in = 5'd6;
        step();
        in_valid = 1'b0;
        chk("pre-rst full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst data_out", data_out, 32'd0);
        chk("async rst tag_out", 32'(tag_out), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; data_in = 16'h0042; tag_in = 5'd8;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        chk("post-rst data", data_out, 32'h00000042);
        chk("post-rst tag", 32'(tag_out), 32'd8);
        step();
        chk("post-rst alone", 32'(out_valid), 32'd0);

        // IN_W == OUT_W instance.
        v16 = 1'b1; m16 = 2'b10; d16 = 16'h1234; t16 = 5'd11;
        step();
        chk("w16 upper passthrough", 32'(do16), 32'h1234);
        chk("w16 tag", 32'(to16), 32'd11);
        m16 = 2'b01; d16 = 16'h8001;
        step();
        chk("w16 sign", 32'(do16), 32'h8001);
        m16 = 2'b11; d16 = 16'h1280;
        step();
        v16 = 1'b0;
        chk("w16 byte sign", 32'(do16), 32'hFF80);
        step();
        chk("w16 drained", 32'(ov16), 32'd0);

`ifdef EXT_PIPE_COUNT_EN
        // Counter wrap: reset, then exactly 0xFFFF pops, then one more.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; mode = 2'b00; out_ready = 1'b1;
        for (int c = 0; c < 65535; c++) begin
            in_valid = 1'b1; data_in = 16'(c);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("count at ffff", 32'(xfer_count), 32'h0000FFFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("count wraps", 32'(xfer_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
